// File: rtl/ram_cache_pkg.sv
// Shared constants, FSM state type and address-slicing helpers for the
// direct-mapped word cache.
package ram_cache_pkg;

   localparam int ADDR_HI = 26;
   localparam int ADDR_LO = 2;
   localparam int ADDR_W  = ADDR_HI - ADDR_LO + 1;
   localparam int DATA_W  = 32;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FILL  = 2'd1,
      WRITE = 2'd2,
      DONE  = 2'd3
   } state_t;

   // Line index: the low idx_w bits of the word address.
   function automatic logic [ADDR_W-1:0] f_index(input logic [ADDR_W-1:0] addr,
                                                 input int idx_w);
      logic [ADDR_W-1:0] mask;
      mask = (25'd1 << idx_w) - 25'd1;
      return addr & mask;
   endfunction

   // Tag: the word address bits above the index.
   function automatic logic [ADDR_W-1:0] f_tag(input logic [ADDR_W-1:0] addr,
                                               input int idx_w);
      return addr >> idx_w;
   endfunction

endpackage

// File: rtl/ram_cache_store.sv
// Valid/tag/data arrays: combinational read port, synchronous write port and
// a synchronous clear-all of the valid bits. A line write with set_valid on
// the same edge as a clear keeps that line valid.
module ram_cache_store
   import ram_cache_pkg::*;
#(
   parameter int IDX_W = 8
) (
   input  logic              clk,
   input  logic              i_clr,
   input  logic [IDX_W-1:0]  i_rd_idx,
   output logic              o_rd_valid,
   output logic [ADDR_W-IDX_W-1:0] o_rd_tag,
   output logic [DATA_W-1:0] o_rd_data,
   input  logic              i_we,
   input  logic              i_set_valid,
   input  logic [IDX_W-1:0]  i_wr_idx,
   input  logic [ADDR_W-IDX_W-1:0] i_wr_tag,
   input  logic [DATA_W-1:0] i_wr_data
);

   localparam int LINES = 2 ** IDX_W;
   localparam int TAG_W = ADDR_W - IDX_W;

   logic [LINES-1:0]  r_valid;
   logic [TAG_W-1:0]  r_tag  [LINES];
   logic [DATA_W-1:0] r_data [LINES];

   // Valid bits: clear-all first, then a setting write overrides its own line.
   always_ff @(posedge clk) begin
      if (i_clr) begin
         r_valid <= {LINES{1'b0}};
      end
      if (i_we && i_set_valid) begin
         r_valid[i_wr_idx] <= 1'b1;
      end
   end

   // Tag and data arrays carry no reset; validity is tracked separately.
   always_ff @(posedge clk) begin
      if (i_we) begin
         r_tag[i_wr_idx]  <= i_wr_tag;
         r_data[i_wr_idx] <= i_wr_data;
      end
   end

   assign o_rd_valid = r_valid[i_rd_idx];
   assign o_rd_tag   = r_tag[i_rd_idx];
   assign o_rd_data  = r_data[i_rd_idx];

endmodule

// File: rtl/ram_cache.sv
// Direct-mapped, write-through, no-write-allocate one-word-per-line cache
// between the CPU data bus and the ram block. All outputs are registered.
module ram_cache
   import ram_cache_pkg::*;
#(
   parameter int IDX_W = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cpu_stb,
   input  logic                  cpu_we,
   input  logic [ADDR_HI:ADDR_LO] cpu_addr,
   input  logic [DATA_W-1:0]     cpu_din,
   output logic [DATA_W-1:0]     cpu_dout,
   output logic                  cpu_ack,
   input  logic                  inv,
   output logic                  ram_stb,
   output logic                  ram_we,
   output logic [ADDR_HI:ADDR_LO] ram_addr,
   output logic [DATA_W-1:0]     ram_din,
   input  logic [DATA_W-1:0]     ram_dout,
   input  logic                  ram_ack
);

   localparam int TAG_W = ADDR_W - IDX_W;

   state_t               r_state;
   logic                 r_cpu_ack;
   logic [DATA_W-1:0]    r_cpu_dout;
   logic                 r_ram_stb;
   logic                 r_ram_we;
   logic [ADDR_W-1:0]    r_ram_addr;
   logic [DATA_W-1:0]    r_ram_din;

   logic [IDX_W-1:0]     w_index;
   logic [TAG_W-1:0]     w_tag;
   logic                 w_rd_valid;
   logic [TAG_W-1:0]     w_rd_tag;
   logic [DATA_W-1:0]    w_rd_data;
   logic                 w_hit;
   logic                 w_we;
   logic                 w_set_valid;
   logic [DATA_W-1:0]    w_wr_data;

   // The CPU holds cpu_addr until ack, so FILL/WRITE reuse it directly.
   assign w_index = IDX_W'(f_index(cpu_addr, IDX_W));
   assign w_tag   = TAG_W'(f_tag(cpu_addr, IDX_W));
   assign w_hit   = w_rd_valid && (w_rd_tag == w_tag);

   ram_cache_store #(.IDX_W(IDX_W)) u_store (
      .clk         (clk),
      .i_clr       (rst | inv),
      .i_rd_idx    (w_index),
      .o_rd_valid  (w_rd_valid),
      .o_rd_tag    (w_rd_tag),
      .o_rd_data   (w_rd_data),
      .i_we        (w_we),
      .i_set_valid (w_set_valid),
      .i_wr_idx    (w_index),
      .i_wr_tag    (w_tag),
      .i_wr_data   (w_wr_data)
   );

   // Line update: a fill validates the line; a write hit only refreshes data.
   always_comb begin
      w_we        = 1'b0;
      w_set_valid = 1'b0;
      w_wr_data   = ram_dout;
      if (!rst && (r_state == FILL) && ram_ack) begin
         w_we        = 1'b1;
         w_set_valid = 1'b1;
         w_wr_data   = ram_dout;
      end else if (!rst && (r_state == WRITE) && ram_ack && w_hit) begin
         w_we        = 1'b1;
         w_set_valid = 1'b0;
         w_wr_data   = cpu_din;
      end else begin
         w_we        = 1'b0;
         w_set_valid = 1'b0;
      end
   end

   // Request FSM with registered CPU and ram handshake outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= IDLE;
         r_cpu_ack  <= 1'b0;
         r_cpu_dout <= 32'd0;
         r_ram_stb  <= 1'b0;
         r_ram_we   <= 1'b0;
         r_ram_addr <= 25'd0;
         r_ram_din  <= 32'd0;
      end else begin
         case (r_state)
            IDLE: begin
               r_cpu_ack <= 1'b0;
               if (cpu_stb) begin
                  if (cpu_we) begin
                     r_ram_stb  <= 1'b1;
                     r_ram_we   <= 1'b1;
                     r_ram_addr <= cpu_addr;
                     r_ram_din  <= cpu_din;
                     r_state    <= WRITE;
                  end else if (w_hit) begin
                     r_cpu_dout <= w_rd_data;
                     r_cpu_ack  <= 1'b1;
                     r_state    <= DONE;
                  end else begin
                     r_ram_stb  <= 1'b1;
                     r_ram_we   <= 1'b0;
                     r_ram_addr <= cpu_addr;
                     r_state    <= FILL;
                  end
               end
            end
            FILL: begin
               if (ram_ack) begin
                  r_cpu_dout <= ram_dout;
                  r_cpu_ack  <= 1'b1;
                  r_ram_stb  <= 1'b0;
                  r_state    <= DONE;
               end
            end
            WRITE: begin
               if (ram_ack) begin
                  r_cpu_ack <= 1'b1;
                  r_ram_stb <= 1'b0;
                  r_ram_we  <= 1'b0;
                  r_state   <= DONE;
               end
            end
            DONE: begin
               r_cpu_ack <= 1'b0;
               r_state   <= IDLE;
            end
            default: begin
               r_cpu_ack <= 1'b0;
               r_ram_stb <= 1'b0;
               r_ram_we  <= 1'b0;
               r_state   <= IDLE;
            end
         endcase
      end
   end

   assign cpu_ack  = r_cpu_ack;
   assign cpu_dout = r_cpu_dout;
   assign ram_stb  = r_ram_stb;
   assign ram_we   = r_ram_we;
   assign ram_addr = r_ram_addr;
   assign ram_din  = r_ram_din;

endmodule

// File: doc/ram_cache.md
Name: ram_cache

Overview:
- Direct-mapped, write-through, no-write-allocate word cache between the CPU data bus and the SDRAM-backed ram block.
- Lines are one 32-bit word each.
- Read hits complete without an SDRAM access.
- Read misses fill one line from ram; writes always go to ram and update the line only on a hit.
- Both sides use the stb/we/addr[26:2]/ack handshake; ram timeouts are handled by the CPU, so the cache never times out.

Parameters:
- IDX_W, 8, index width in bits; LINES = 2**IDX_W; legal range 2..12.
- TAG_W, 25-IDX_W, tag width; derived, not overridable.

Ports:
- clk  in  1  system clock, single clock domain.
- rst  in  1  reset, synchronous, active-high.
- cpu_stb  in  1  CPU request strobe; held until cpu_ack.
- cpu_we  in  1  1 = write, 0 = read; valid with cpu_stb.
- cpu_addr  in  25 [26:2]  word address.
- cpu_din  in  32  write data.
- cpu_dout  out  32  read data; valid while cpu_ack=1.
- cpu_ack  out  1  one-cycle completion pulse.
- inv  in  1  invalidate-all pulse.
- ram_stb  out  1  request to ram.
- ram_we  out  1  ram write enable.
- ram_addr  out  25 [26:2]  ram word address.
- ram_din  out  32  data to ram.
- ram_dout  in  32  data from ram; valid with ram_ack.
- ram_ack  in  1  ram completion pulse.

Behaviour:
- Address split:
  - index = cpu_addr[IDX_W+1:2]
  - tag = cpu_addr[26:IDX_W+2]
  - hit = valid[index] && tag_mem[index]==tag, evaluated combinationally in IDLE.
- Reset values:
  - state=IDLE.
  - All valid bits = 0.
  - cpu_ack=0, cpu_dout=0.
  - ram_stb=0, ram_we=0, ram_addr=0, ram_din=0.
  - Tag and data arrays need no reset.
- All outputs are registered.
- FSM states: IDLE, FILL, WRITE, DONE.
- IDLE, when cpu_stb=1:
  - Read hit: cpu_dout<=data_mem[index], cpu_ack<=1, go to DONE. Latency: ack visible the cycle after stb is sampled.
  - Read miss: ram_stb<=1, ram_we<=0, ram_addr<=cpu_addr, go to FILL.
  - Write: ram_stb<=1, ram_we<=1, ram_addr<=cpu_addr, ram_din<=cpu_din, go to WRITE.
  - cpu_stb=0: stay in IDLE.
- FILL:
  - Hold the ram request until ram_ack.
  - On ram_ack: data_mem[index]<=ram_dout, tag_mem[index]<=tag, valid[index]<=1, cpu_dout<=ram_dout, cpu_ack<=1, ram_stb<=0, go to DONE.
- WRITE:
  - On ram_ack: if the line hits (re-evaluated), data_mem[index]<=cpu_din, else no change.
  - Then cpu_ack<=1, ram_stb<=0, ram_we<=0, go to DONE.
- DONE:
  - cpu_ack=1 for this single cycle; cpu_ack<=0 at the following edge.
  - cpu_stb is ignored in DONE; go to IDLE.
  - Back-to-back requests therefore take a minimum of 2 cycles each.
- CPU request stability: the CPU holds cpu_addr, cpu_we and cpu_din stable from stb until ack. The cache re-uses cpu_addr in FILL/WRITE rather than a private copy.
- ram_ack while in IDLE or DONE: ignored, no state change.
- inv=1 clears every valid bit at the next edge, in any state.
  - If a FILL completes on the same edge, the fill's valid set for that line wins; all other lines are cleared.
  - An in-flight write is unaffected.
- rst=1 mid-FILL or mid-WRITE: ram_stb drops at the next edge and the transaction is abandoned. A late ram_ack is then ignored (IDLE rule).
- Address wrap: no special case. Addresses differing only in tag alias to the same line; the last fill wins.

Decomposition:
- Package ram_cache_pkg holds:
  - ADDR_HI=26, ADDR_LO=2, DATA_W=32.
  - State typedef state_t {IDLE, FILL, WRITE, DONE}.
  - Index/tag slicing functions parameterised by IDX_W.
- Sub-module ram_cache_store holds the valid, tag and data arrays, with:
  - one combinational read port (index -> valid, tag, data);
  - one synchronous write port (index, tag, data, set_valid);
  - a synchronous clear-all driven by rst|inv.
- The FSM and handshake logic stay in ram_cache.

Test Plan:
- Reset then read 0x0000040 with the ram model at 3-cycle latency returning 0xDEADBEEF:
  - ram_stb is seen once with ram_addr=0x0000040;
  - cpu_dout=0xDEADBEEF with a 1-cycle cpu_ack.
  - A repeat read gives ack 1 cycle after stb with no ram_stb.
- Write 0x12345678 to the cached 0x0000040: ram_we=1 and ram_din=0x12345678 reach ram. A subsequent read hits and returns 0x12345678 without ram_stb.
- Write 0xCAFEF00D to the uncached 0x0000080: ram is written. A following read of 0x0000080 misses and issues a ram read (no write-allocate).
- Read 0x0000040 then 0x0000440 (same index, IDX_W=8, different tag): both miss. Re-reading 0x0000040 misses again (eviction).
- Pulse inv after the lines are filled: the next read of 0x0000040 issues ram_stb. Assert inv on the same edge as the FILL ram_ack: the filled line remains valid.
- Assert rst during FILL before ram_ack: ram_stb=0 next cycle. A late ram_ack causes no cpu_ack and no line becomes valid.
